// File: rtl/fixed_point_addsub_pipe.sv
// Signed fixed-point add/subtract with per-operand Q-formats, a 2-stage valid/ready pipeline
// and a saturating overflow counter. Define FXADD_SAT_EN to clamp on overflow instead of wrapping.
`timescale 1ns/1ps
module fixed_point_addsub_pipe #(
   parameter int DW_A   = 8,
   parameter int FRAC_A = 4,
   parameter int DW_B   = 8,
   parameter int FRAC_B = 4,
   parameter int DW_O   = 8,
   parameter int FRAC_O = 4,
   parameter int CNT_W  = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [DW_A-1:0]  i_a,
   input  logic [DW_B-1:0]  i_b,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [DW_O-1:0]  o_data,
   output logic             o_ovf,
   output logic [CNT_W-1:0] o_ovf_cnt,
   input  logic             i_ovf_clr
);

   localparam int IW_A = DW_A - FRAC_A;
   localparam int IW_B = DW_B - FRAC_B;
   localparam int IW   = (IW_A > IW_B) ? IW_A : IW_B;
   localparam int FI   = (FRAC_A > FRAC_B) ? FRAC_A : FRAC_B;
   localparam int FW   = IW + FI + 1;
   localparam int SH_A = FI - FRAC_A;
   localparam int SH_B = FI - FRAC_B;
   localparam int S    = FI - FRAC_O;
   // One guard bit above the sum keeps the rounding bias from overflowing.
   localparam int CW   = ((FW + 1) > (DW_O + 1)) ? (FW + 1) : (DW_O + 1);

   localparam logic signed [CW-1:0] RND_BIAS = (CW'(1) << S) >> 1;
   localparam logic signed [CW-1:0] O_MAX    = {{(CW-DW_O+1){1'b0}}, {(DW_O-1){1'b1}}};
   localparam logic signed [CW-1:0] O_MIN    = {{(CW-DW_O+1){1'b1}}, {(DW_O-1){1'b0}}};

   if (FRAC_O > FI) begin : g_frac_o_check
      $error("FRAC_O must not exceed max(FRAC_A, FRAC_B)");
   end

   logic                    ready_en_q;
   logic                    s1_valid_q, s1_valid_d;
   logic signed [FW-1:0]    s1_sum_q, s1_sum_d;
   logic                    s2_valid_q, s2_valid_d;
   logic [DW_O-1:0]         s2_data_q, s2_data_d;
   logic                    s2_ovf_q, s2_ovf_d;
   logic [CNT_W-1:0]        ovf_cnt_q, ovf_cnt_d;

   logic                    s2_load;
   logic                    s1_advance;
   logic                    out_xfer;
   logic signed [FW-1:0]    a_al, b_al, sum_al;
   logic signed [CW-1:0]    sum_x, rnd;
   logic                    rnd_ovf;
   logic [DW_O-1:0]         rnd_data;

   // Stage 1: align both operands to FI fractional bits and add at a width that cannot overflow.
   always_comb begin
      a_al   = {{(FW-DW_A){i_a[DW_A-1]}}, i_a} << SH_A;
      b_al   = {{(FW-DW_B){i_b[DW_B-1]}}, i_b} << SH_B;
      sum_al = i_sub ? (a_al - b_al) : (a_al + b_al);
   end

   // Stage 2: round half up, then range-check against the output format.
   always_comb begin
      sum_x   = {{(CW-FW){s1_sum_q[FW-1]}}, s1_sum_q};
      rnd     = (sum_x + RND_BIAS) >>> S;
      rnd_ovf = (rnd > O_MAX) || (rnd < O_MIN);
`ifdef FXADD_SAT_EN
      if (rnd > O_MAX) begin
         rnd_data = O_MAX[DW_O-1:0];
      end else if (rnd < O_MIN) begin
         rnd_data = O_MIN[DW_O-1:0];
      end else begin
         rnd_data = rnd[DW_O-1:0];
      end
`else
      rnd_data = rnd[DW_O-1:0];
`endif
   end

   always_comb begin
      s2_load    = !s2_valid_q || i_ready;
      s1_advance = s2_load;
      o_ready    = ready_en_q && (!s1_valid_q || s1_advance);
      out_xfer   = s2_valid_q && i_ready;

      // NOTE: every next-state value gets a default hold first, so no latch can be inferred.
      s1_valid_d = s1_valid_q;
      s1_sum_d   = s1_sum_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_ovf_d   = s2_ovf_q;
      ovf_cnt_d  = ovf_cnt_q;

      if (o_ready) begin
         s1_valid_d = i_valid;
         if (i_valid) begin
            s1_sum_d = sum_al;
         end
      end

      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = rnd_data;
            s2_ovf_d  = rnd_ovf;
         end
      end

      // A clear in the same cycle as a counting transfer leaves the counter at zero.
      if (i_ovf_clr) begin
         ovf_cnt_d = '0;
      end else if (out_xfer && s2_ovf_q && !(&ovf_cnt_q)) begin
         ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state is only ever updated with non-blocking assignments from the _d values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ready_en_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_ovf_q   <= 1'b0;
         ovf_cnt_q  <= '0;
      end else begin
         ready_en_q <= 1'b1;
         s1_valid_q <= s1_valid_d;
         s1_sum_q   <= s1_sum_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_ovf_q   <= s2_ovf_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

   assign o_valid   = s2_valid_q;
   assign o_data    = s2_data_q;
   assign o_ovf     = s2_ovf_q;
   assign o_ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Bench for fixed_point_addsub_pipe: a default instance and a FRAC_A=6 / CNT_W=2 instance share stimulus;
// a real-arithmetic model feeds a scoreboard checked every cycle, plus directed literal vectors.
`timescale 1ns/1ps
module tb_fixed_point_addsub_pipe;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
   } smp_t;

   logic        clk = 1'b0;
   logic        i_reset, i_valid, i_sub, i_ready, i_ovf_clr;
   logic [7:0]  i_a, i_b;
   logic        o_ready0, o_valid0, o_ovf0;
   logic [7:0]  o_data0;
   logic [15:0] o_ovf_cnt0;
   logic        o_ready6, o_valid6, o_ovf6;
   logic [7:0]  o_data6;
   logic [1:0]  o_ovf_cnt6;

   int n_checks = 0;
   int n_errors = 0;
   int n_out    = 0;

   smp_t       sb[$];
   int         m_cnt0, m_cnt6;
   logic [7:0] m_d0, m_d6;
   logic       m_o0, m_o6;
   logic       held;
   logic [7:0] held_d0;
   logic       held_o0;

   always #5 clk = ~clk;

   fixed_point_addsub_pipe u_dut (
      .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready0),
      .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(o_valid0), .i_ready(i_ready),
      .o_data(o_data0), .o_ovf(o_ovf0), .o_ovf_cnt(o_ovf_cnt0), .i_ovf_clr(i_ovf_clr)
   );

   fixed_point_addsub_pipe #(.FRAC_A(6), .CNT_W(2)) u_dut6 (
      .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready6),
      .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(o_valid6), .i_ready(i_ready),
      .o_data(o_data6), .o_ovf(o_ovf6), .o_ovf_cnt(o_ovf_cnt6), .i_ovf_clr(i_ovf_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Exact real-valued result scaled to the Q4.4 output, rounded half up, then limited.
   function automatic void model(input smp_t s, input int fa, output logic [7:0] d, output logic ovf);
      real    ra, rb, rs;
      longint r;
      ra  = real'($signed(s.a)) / real'(longint'(1) << fa);
      rb  = real'($signed(s.b)) / 16.0;
      rs  = s.sub ? (ra - rb) : (ra + rb);
      r   = longint'($floor(rs * 16.0 + 0.5));
      ovf = (r > 127) || (r < -128);
`ifdef FXADD_SAT_EN
      d = ovf ? ((r < 0) ? 8'h80 : 8'h7F) : 8'(r);
`else
      d = 8'(r);
`endif
   endfunction

   // Scoreboard compare, sampled on the falling edge.
   always @(negedge clk) begin
      if (i_reset) begin
         sb.delete();
         m_cnt0 = 0;
         m_cnt6 = 0;
         held   = 1'b0;
      end else begin
         check("cnt0", o_ovf_cnt0, m_cnt0);
         check("cnt6", o_ovf_cnt6, m_cnt6);
         check("ready_match", o_ready6, o_ready0);
         check("valid_match", o_valid6, o_valid0);
         if (held) begin
            check("hold_valid", o_valid0, 1'b1);
            check("hold_data", o_data0, held_d0);
            check("hold_ovf", o_ovf0, held_o0);
         end
         if (o_valid0) begin
            if (sb.size() == 0) begin
               check("spurious_out", o_valid0, 1'b0);
            end else begin
               model(sb[0], 4, m_d0, m_o0);
               model(sb[0], 6, m_d6, m_o6);
               check("sb_data0", o_data0, m_d0);
               check("sb_ovf0", o_ovf0, m_o0);
               check("sb_data6", o_data6, m_d6);
               check("sb_ovf6", o_ovf6, m_o6);
               if (i_ready) begin
                  void'(sb.pop_front());
                  n_out++;
                  if (!i_ovf_clr && m_o0 && m_cnt0 < 65535) m_cnt0++;
                  if (!i_ovf_clr && m_o6 && m_cnt6 < 3) m_cnt6++;
               end
            end
         end
         if (i_ovf_clr) begin
            m_cnt0 = 0;
            m_cnt6 = 0;
         end
         held    = o_valid0 && !i_ready;
         held_d0 = o_data0;
         held_o0 = o_ovf0;
         if (i_valid && o_ready0) sb.push_back('{a: i_a, b: i_b, sub: i_sub});
      end
   end

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic sub);
      int k;
      i_valid = 1'b1;
      i_a     = a;
      i_b     = b;
      i_sub   = sub;
      k       = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!o_ready0 && k < 50);
      if (!o_ready0) check("push_timeout", o_ready0, 1'b1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic run_one(input string nm, input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input logic [7:0] e0, input logic eo0, input logic c6, input logic [7:0] e6);
      push(a, b, sub);
      check({nm, "_early"}, o_valid0, 1'b0);
      @(posedge clk);
      #1;
      check({nm, "_valid"}, o_valid0, 1'b1);
      check({nm, "_data"}, o_data0, e0);
      check({nm, "_ovf"}, o_ovf0, eo0);
      if (c6) check({nm, "_data6"}, o_data6, e6);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      smp_t       s;
      logic [7:0] d;
      logic       ov;
      int         base;

      i_reset = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_sub = 1'b0;
      i_ready = 1'b1; i_ovf_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", o_valid0, 1'b0);
      check("rst_data", o_data0, 8'h00);
      check("rst_ovf", o_ovf0, 1'b0);
      check("rst_cnt", o_ovf_cnt0, 16'h0);
      check("rst_valid6", o_valid6, 1'b0);

      s = '{a: 8'h18, b: 8'h24, sub: 1'b0};
      model(s, 4, d, ov);
      check("model_add", d, 8'h3C);
      s = '{a: 8'hFA, b: 8'h00, sub: 1'b0};
      model(s, 6, d, ov);
      check("model_rnd", d, 8'hFF);

      @(negedge clk);
      #1;
      i_reset = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_rst", o_ready0, 1'b1);

      run_one("add", 8'h18, 8'h24, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00);
      run_one("sub", 8'h10, 8'h30, 1'b1, 8'hE0, 1'b0, 1'b0, 8'h00);
`ifdef FXADD_SAT_EN
      run_one("ovf_pos", 8'h70, 8'h20, 1'b0, 8'h7F, 1'b1, 1'b0, 8'h00);
      check("cnt_one", o_ovf_cnt0, 16'd1);
      run_one("ovf_neg", 8'h80, 8'hF0, 1'b0, 8'h80, 1'b1, 1'b0, 8'h00);
`else
      run_one("ovf_pos", 8'h70, 8'h20, 1'b0, 8'h90, 1'b1, 1'b0, 8'h00);
      check("cnt_one", o_ovf_cnt0, 16'd1);
      run_one("ovf_neg", 8'h80, 8'hF0, 1'b0, 8'h70, 1'b1, 1'b0, 8'h00);
`endif
      check("cnt_two", o_ovf_cnt0, 16'd2);
      run_one("frac_pos", 8'h06, 8'h00, 1'b0, 8'h06, 1'b0, 1'b1, 8'h02);
      run_one("frac_neg", 8'hFA, 8'h00, 1'b0, 8'hFA, 1'b0, 1'b1, 8'hFF);
      run_one("negb", 8'hF0, 8'h80, 1'b1, 8'h70, 1'b0, 1'b1, 8'h7C);

      // Four overflowing samples push the 2-bit counter to its ceiling.
      for (int i = 0; i < 4; i++) push(8'h7F, 8'h7F, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("cnt6_sat", o_ovf_cnt6, 2'd3);
      check("cnt0_six", o_ovf_cnt0, 16'd6);

      // Backpressure: two samples fill the pipe, the head holds, then all four drain in order.
      base    = n_out;
      i_ready = 1'b0;
      push(8'h01, 8'h02, 1'b0);
      push(8'h03, 8'h04, 1'b0);
      check("bp_ready_low", o_ready0, 1'b0);
      check("bp_head", o_data0, 8'h03);
      repeat (3) @(posedge clk);
      #1;
      check("bp_head_held", o_data0, 8'h03);
      i_ready = 1'b1;
      push(8'h05, 8'h06, 1'b1);
      push(8'h07, 8'h08, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("bp_count", n_out - base, 4);

      // Clear coincident with an overflowing output transfer wins.
      i_ready = 1'b0;
      push(8'h70, 8'h20, 1'b0);
      @(posedge clk);
      #1;
      check("clr_pending", o_valid0, 1'b1);
      i_ovf_clr = 1'b1;
      i_ready   = 1'b1;
      @(posedge clk);
      #1;
      i_ovf_clr = 1'b0;
      check("clr_wins", o_ovf_cnt0, 16'd0);
      check("clr_drained", o_valid0, 1'b0);

      // Reset with two samples in flight discards them.
      i_ready = 1'b0;
      push(8'h01, 8'h02, 1'b0);
      push(8'h03, 8'h04, 1'b0);
      #1;
      i_reset = 1'b1;
      #1;
      check("rst_mid_valid", o_valid0, 1'b0);
      check("rst_mid_valid6", o_valid6, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      i_reset = 1'b0;
      i_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         check("post_rst_quiet", o_valid0, 1'b0);
      end
      check("post_rst_cnt", o_ovf_cnt0, 16'd0);

      run_one("after_rst", 8'h18, 8'h24, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      check("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
